// File: rtl/egreedy_pkg.sv
// Shared types, widths and arithmetic helpers for the epsilon-greedy exploration source.
package egreedy_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam int unsigned LfsrW = 16;
   localparam int unsigned EpsW  = 16;
   localparam int unsigned EpW   = 8;
   localparam logic [LfsrW-1:0] LfsrTaps = 16'hB400;

   // Right-shifting Galois step: fold the taps in when the outgoing bit is set.
   function automatic logic [LfsrW-1:0] lfsr_next(input logic [LfsrW-1:0] cur);
      return (cur >> 1) ^ (cur[0] ? LfsrTaps : '0);
   endfunction

   function automatic logic [EpsW-1:0] eps_decay(input logic [EpsW-1:0] eps,
                                                 input int unsigned     shift,
                                                 input logic [EpsW-1:0] floor);
      logic [EpsW-1:0] r;
      r = eps - (eps >> shift);
      return (r < floor) ? floor : r;
   endfunction

endpackage

// File: rtl/egreedy_gen_if.sv
// Step handshake and action/status bundle between the exploration source and its consumer.
interface egreedy_gen_if;
   import egreedy_pkg::*;

   logic            start;
   logic            step;
   logic [1:0]      Arand_A;
   logic [1:0]      Arand_B;
   logic            Asel_A;
   logic            Asel_B;
   logic            learning;
   logic            valid;
   logic [EpsW-1:0] epsilon;
   logic [EpW-1:0]  episode;
   logic            done;

   modport master (
      output start, step,
      input  Arand_A, Arand_B, Asel_A, Asel_B, learning, valid, epsilon, episode, done
   );

   modport slave (
      input  start, step,
      output Arand_A, Arand_B, Asel_A, Asel_B, learning, valid, epsilon, episode, done
   );

endinterface

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR that loads its seed on reset (zero seed forced to 1) and steps on adv_i.
module lfsr16_galois
   import egreedy_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             adv_i,
   input  logic [LfsrW-1:0] seed_i,
   output logic [LfsrW-1:0] q_o
);

   logic [LfsrW-1:0] q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= (seed_i == '0) ? LfsrW'(1) : seed_i;
      end else if (adv_i) begin
         q_q <= lfsr_next(q_q);
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/egreedy_gen.sv
// Epsilon-greedy action source for two intersections with per-episode epsilon decay.
// Define EGREEDY_FIXED_EPS_EN to hold epsilon at EPS_INIT for the whole run.
module egreedy_gen
   import egreedy_pkg::*;
#(
   parameter logic [LfsrW-1:0] SEED_A            = 16'hACE1,
   parameter logic [LfsrW-1:0] SEED_B            = 16'h1D2B,
   parameter logic [EpsW-1:0]  EPS_INIT          = 16'hFFFF,
   parameter logic [EpsW-1:0]  EPS_MIN           = 16'h0CCD,
   parameter int unsigned      DECAY_SHIFT       = 6,
   parameter int unsigned      STEPS_PER_EPISODE = 64,
   parameter int unsigned      N_EPISODES        = 100
) (
   input logic          clk,
   input logic          rst,
   egreedy_gen_if.slave bus
);

   localparam logic [15:0]    LastStep = 16'(STEPS_PER_EPISODE - 1);
   localparam logic [EpW-1:0] NumEp    = EpW'(N_EPISODES);

   state_e          state_q, state_d;
   logic [EpsW-1:0] eps_q, eps_d;
   logic [EpW-1:0]  ep_q, ep_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [1:0]      arand_a_q, arand_a_d, arand_b_q, arand_b_d;
   logic            asel_a_q, asel_a_d, asel_b_q, asel_b_d;
   logic            valid_q, valid_d;

   logic             step_acc;
   logic [LfsrW-1:0] lfsr_a, lfsr_b, next_a, next_b;

   // A step coinciding with start is dropped entirely.
   assign step_acc = bus.step & ~bus.start;
   assign next_a   = lfsr_next(lfsr_a);
   assign next_b   = lfsr_next(lfsr_b);

   lfsr16_galois u_lfsr_a (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (step_acc),
      .seed_i (SEED_A),
      .q_o    (lfsr_a)
   );

   lfsr16_galois u_lfsr_b (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (step_acc),
      .seed_i (SEED_B),
      .q_o    (lfsr_b)
   );

   always_comb begin
      state_d   = state_q;
      eps_d     = eps_q;
      ep_d      = ep_q;
      cnt_d     = cnt_q;
      arand_a_d = arand_a_q;
      arand_b_d = arand_b_q;
      asel_a_d  = asel_a_q;
      asel_b_d  = asel_b_q;
      valid_d   = 1'b0;

      if (step_acc) begin
         arand_a_d = next_a[1:0];
         arand_b_d = next_b[1:0];
         asel_a_d  = (state_q == StRun) ? (next_a >= eps_q) : 1'b1;
         asel_b_d  = (state_q == StRun) ? (next_b >= eps_q) : 1'b1;
         valid_d   = 1'b1;
      end

      if (bus.start) begin
         state_d = StRun;
         eps_d   = EPS_INIT;
         ep_d    = '0;
         cnt_d   = '0;
      end else if (state_q == StRun && step_acc) begin
         if (cnt_q == LastStep) begin
            cnt_d = '0;
            ep_d  = ep_q + 1'b1;
`ifdef EGREEDY_FIXED_EPS_EN
            eps_d = eps_q;
`else
            eps_d = eps_decay(eps_q, DECAY_SHIFT, EPS_MIN);
`endif
            if (ep_d == NumEp) begin
               state_d = StDone;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         eps_q     <= EPS_INIT;
         ep_q      <= '0;
         cnt_q     <= '0;
         arand_a_q <= '0;
         arand_b_q <= '0;
         asel_a_q  <= 1'b1;
         asel_b_q  <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         eps_q     <= eps_d;
         ep_q      <= ep_d;
         cnt_q     <= cnt_d;
         arand_a_q <= arand_a_d;
         arand_b_q <= arand_b_d;
         asel_a_q  <= asel_a_d;
         asel_b_q  <= asel_b_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.Arand_A  = arand_a_q;
   assign bus.Arand_B  = arand_b_q;
   assign bus.Asel_A   = asel_a_q;
   assign bus.Asel_B   = asel_b_q;
   assign bus.valid    = valid_q;
   assign bus.learning = (state_q == StRun);
   assign bus.done     = (state_q == StDone);
   assign bus.epsilon  = eps_q;
   assign bus.episode  = ep_q;

endmodule

// File: tb/tb_egreedy_gen.sv
// Self-checking bench: directed scenarios on three configurations plus randomized run vs a model.
module tb_egreedy_gen;

   logic clk = 1'b0;
   logic rst_c = 1'b1;
   logic rst_r = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   egreedy_gen_if if_def ();
   egreedy_gen_if if_small ();
   egreedy_gen_if if_clamp ();
   egreedy_gen_if if_rnd ();

   egreedy_gen u_def (.clk(clk), .rst(rst_c), .bus(if_def));

   egreedy_gen #(.STEPS_PER_EPISODE(4), .N_EPISODES(2)) u_small (
      .clk(clk), .rst(rst_c), .bus(if_small));

   egreedy_gen #(.EPS_INIT(16'h0D00), .DECAY_SHIFT(1), .STEPS_PER_EPISODE(1), .N_EPISODES(3))
      u_clamp (.clk(clk), .rst(rst_c), .bus(if_clamp));

   localparam logic [15:0] RSeedA = 16'h0000;
   localparam logic [15:0] RSeedB = 16'h1234;
   localparam logic [15:0] REpsInit = 16'h9000;
   localparam logic [15:0] REpsMin = 16'h2000;
   localparam int RShift = 2;
   localparam int RSteps = 3;
   localparam int REps = 4;

   egreedy_gen #(.SEED_A(RSeedA), .SEED_B(RSeedB), .EPS_INIT(REpsInit), .EPS_MIN(REpsMin),
                 .DECAY_SHIFT(RShift), .STEPS_PER_EPISODE(RSteps), .N_EPISODES(REps))
      u_rnd (.clk(clk), .rst(rst_r), .bus(if_rnd));

`ifdef EGREEDY_FIXED_EPS_EN
   localparam logic [15:0] SmallE1 = 16'hFFFF;
   localparam logic [15:0] SmallE2 = 16'hFFFF;
   localparam logic [15:0] ClampE = 16'h0D00;
   localparam bit FixedEps = 1'b1;
`else
   localparam logic [15:0] SmallE1 = 16'hFC00;
   localparam logic [15:0] SmallE2 = 16'hF810;
   localparam logic [15:0] ClampE = 16'h0CCD;
   localparam bit FixedEps = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model of the randomized instance: plain integer bookkeeping of the rules.
   int          m_mode;  // 0 idle, 1 running, 2 finished
   int          m_ep, m_cnt;
   logic [15:0] m_la, m_lb, m_eps;
   logic [1:0]  m_ra, m_rb;
   logic        m_sa, m_sb, m_valid;

   function automatic logic [15:0] galois(input logic [15:0] x);
      return (x / 2) ^ ((x % 2 == 1) ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_clock(input logic rs, input logic st, input logic sp);
      logic [15:0] dec;
      if (rs) begin
         m_mode = 0; m_ep = 0; m_cnt = 0; m_eps = REpsInit;
         m_la = (RSeedA == 0) ? 16'd1 : RSeedA;
         m_lb = (RSeedB == 0) ? 16'd1 : RSeedB;
         m_ra = 0; m_rb = 0; m_sa = 1; m_sb = 1; m_valid = 0;
         return;
      end
      m_valid = sp && !st;
      if (m_valid) begin
         m_la = galois(m_la);
         m_lb = galois(m_lb);
         m_ra = 2'(m_la % 4);
         m_rb = 2'(m_lb % 4);
         m_sa = (m_mode == 1) ? (m_la >= m_eps) : 1'b1;
         m_sb = (m_mode == 1) ? (m_lb >= m_eps) : 1'b1;
      end
      if (st) begin
         m_mode = 1; m_eps = REpsInit; m_ep = 0; m_cnt = 0;
      end else if (m_mode == 1 && m_valid) begin
         m_cnt++;
         if (m_cnt == RSteps) begin
            m_cnt = 0;
            m_ep++;
            if (!FixedEps) begin
               dec = m_eps - 16'(m_eps / (1 << RShift));
               m_eps = (dec < REpsMin) ? REpsMin : dec;
            end
            if (m_ep == REps) m_mode = 2;
         end
      end
   endtask

   typedef struct {
      logic        start;
      logic        step;
      logic        valid;
      logic        learning;
      logic        done;
      logic [7:0]  ep;
      logic [15:0] eps;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1, 0, 0, 1, 0, 8'd0, 16'hFFFF};
      tbl[1]  = '{0, 1, 1, 1, 0, 8'd0, 16'hFFFF};
      tbl[2]  = '{0, 1, 1, 1, 0, 8'd0, 16'hFFFF};
      tbl[3]  = '{0, 1, 1, 1, 0, 8'd0, 16'hFFFF};
      tbl[4]  = '{0, 1, 1, 1, 0, 8'd1, SmallE1};
      tbl[5]  = '{0, 1, 1, 1, 0, 8'd1, SmallE1};
      tbl[6]  = '{0, 1, 1, 1, 0, 8'd1, SmallE1};
      tbl[7]  = '{0, 1, 1, 1, 0, 8'd1, SmallE1};
      tbl[8]  = '{0, 1, 1, 0, 1, 8'd2, SmallE2};
      tbl[9]  = '{0, 0, 0, 0, 1, 8'd2, SmallE2};
      tbl[10] = '{0, 1, 1, 0, 1, 8'd2, SmallE2};
      tbl[11] = '{1, 0, 0, 1, 0, 8'd0, 16'hFFFF};
      tbl[12] = '{1, 1, 0, 1, 0, 8'd0, 16'hFFFF};
      tbl[13] = '{0, 1, 1, 1, 0, 8'd0, 16'hFFFF};

      {if_def.start, if_def.step, if_small.start, if_small.step} = '0;
      {if_clamp.start, if_clamp.step, if_rnd.start, if_rnd.step} = '0;
      tick();
      tick();

      // Reset values
      chk("rst Arand_A", 32'(if_def.Arand_A), 0);
      chk("rst Asel_A", 32'(if_def.Asel_A), 1);
      chk("rst Asel_B", 32'(if_def.Asel_B), 1);
      chk("rst valid", 32'(if_def.valid), 0);
      chk("rst learning", 32'(if_def.learning), 0);
      chk("rst done", 32'(if_def.done), 0);
      chk("rst epsilon", 32'(if_def.epsilon), 32'hFFFF);
      chk("rst episode", 32'(if_def.episode), 0);

      // Step while idle
      rst_c = 1'b0;
      if_def.step = 1'b1;
      tick();
      if_def.step = 1'b0;
      chk("idle Arand_A", 32'(if_def.Arand_A), 0);
      chk("idle Arand_B", 32'(if_def.Arand_B), 1);
      chk("idle Asel_A", 32'(if_def.Asel_A), 1);
      chk("idle learning", 32'(if_def.learning), 0);
      chk("idle valid", 32'(if_def.valid), 1);
      tick();
      chk("idle valid pulse", 32'(if_def.valid), 0);
      chk("idle Arand_B hold", 32'(if_def.Arand_B), 1);

      // Step while running
      rst_c = 1'b1; tick(); rst_c = 1'b0;
      if_def.start = 1'b1; tick(); if_def.start = 1'b0;
      if_def.step = 1'b1; tick(); if_def.step = 1'b0;
      chk("run Asel_A", 32'(if_def.Asel_A), 0);
      chk("run Asel_B", 32'(if_def.Asel_B), 0);
      chk("run Arand_B", 32'(if_def.Arand_B), 1);
      chk("run learning", 32'(if_def.learning), 1);
      chk("run valid", 32'(if_def.valid), 1);

      // start+step collision, then reset mid-episode with a step in flight
      rst_c = 1'b1; tick(); rst_c = 1'b0;
      if_def.start = 1'b1; if_def.step = 1'b1; tick(); if_def.start = 1'b0;
      chk("collide valid", 32'(if_def.valid), 0);
      chk("collide learning", 32'(if_def.learning), 1);
      tick();
      chk("collide Arand_B", 32'(if_def.Arand_B), 1);
      chk("collide valid2", 32'(if_def.valid), 1);
      tick();
      rst_c = 1'b1; tick(); rst_c = 1'b0;
      chk("midrst valid", 32'(if_def.valid), 0);
      chk("midrst learning", 32'(if_def.learning), 0);
      chk("midrst Asel_A", 32'(if_def.Asel_A), 1);
      chk("midrst Arand_B", 32'(if_def.Arand_B), 0);
      chk("midrst epsilon", 32'(if_def.epsilon), 32'hFFFF);
      tick();
      if_def.step = 1'b0;
      chk("postrst Arand_B", 32'(if_def.Arand_B), 1);

      // Episode/decay table on the short-episode instance
      for (int i = 0; i < 14; i++) begin
         if_small.start = tbl[i].start;
         if_small.step = tbl[i].step;
         tick();
         chk($sformatf("tbl[%0d] valid", i), 32'(if_small.valid), 32'(tbl[i].valid));
         chk($sformatf("tbl[%0d] learning", i), 32'(if_small.learning), 32'(tbl[i].learning));
         chk($sformatf("tbl[%0d] done", i), 32'(if_small.done), 32'(tbl[i].done));
         chk($sformatf("tbl[%0d] episode", i), 32'(if_small.episode), 32'(tbl[i].ep));
         chk($sformatf("tbl[%0d] epsilon", i), 32'(if_small.epsilon), 32'(tbl[i].eps));
      end
      if_small.start = 1'b0;
      if_small.step = 1'b0;

      // Floor clamp with one step per episode
      if_clamp.start = 1'b1; tick(); if_clamp.start = 1'b0;
      chk("clamp init", 32'(if_clamp.epsilon), 32'h0D00);
      for (int i = 1; i <= 3; i++) begin
         if_clamp.step = 1'b1; tick();
         chk($sformatf("clamp eps %0d", i), 32'(if_clamp.epsilon), 32'(ClampE));
         chk($sformatf("clamp ep %0d", i), 32'(if_clamp.episode), i);
      end
      if_clamp.step = 1'b0;
      chk("clamp done", 32'(if_clamp.done), 1);

      // Randomized run against the model
      if_rnd.start = 1'b0; if_rnd.step = 1'b0; rst_r = 1'b1;
      model_clock(1'b1, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 1500; c++) begin
         rst_r = ($urandom_range(149) == 0);
         if_rnd.start = ($urandom_range(39) == 0);
         if_rnd.step = $urandom_range(1);
         model_clock(rst_r, if_rnd.start, if_rnd.step);
         tick();
         chk("rnd ctrl",
             32'({if_rnd.Arand_A, if_rnd.Arand_B, if_rnd.Asel_A, if_rnd.Asel_B, if_rnd.valid,
                  if_rnd.learning, if_rnd.done}),
             32'({m_ra, m_rb, m_sa, m_sb, m_valid, m_mode == 1, m_mode == 2}));
         chk("rnd eps/ep", {8'd0, if_rnd.epsilon, if_rnd.episode}, {8'd0, m_eps, 8'(m_ep)});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/egreedy_gen.md
Name: egreedy_gen

Overview:
Upstream exploration source for the two-intersection policy generator. On each step request it produces one random action per intersection (Arand_A/Arand_B) and one greedy/explore select per intersection (Asel_A/Asel_B). It also drives the `learning` flag.
Epsilon is held internally as a fixed-point threshold. It decays geometrically at every episode boundary until a floor is reached. Learning ends after a fixed number of episodes.

Parameters:
SEED_A, 16'hACE1, LFSR seed for intersection A (0 is replaced by 16'h0001)
SEED_B, 16'h1D2B, LFSR seed for intersection B (0 is replaced by 16'h0001)
EPS_INIT, 16'hFFFF, initial epsilon, Q0.16
EPS_MIN, 16'h0CCD, epsilon floor, Q0.16; EPS_INIT >= EPS_MIN required
DECAY_SHIFT, 6, decay factor (1 - 2^-DECAY_SHIFT) per episode; range 1..15
STEPS_PER_EPISODE, 64, steps per episode; range 1..65535
N_EPISODES, 100, episodes before learning ends; range 1..255

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; begin or restart learning
step  in  1  one-cycle pulse; request a new action pair
Arand_A  out  2  random action, intersection A
Arand_B  out  2  random action, intersection B
Asel_A  out  1  1 = take greedy action, 0 = explore; intersection A
Asel_B  out  1  same as Asel_A, intersection B
learning  out  1  high while in RUN
valid  out  1  one-cycle pulse; new Arand/Asel values present
epsilon  out  16  current epsilon
episode  out  8  completed-episode count
done  out  1  high in DONE

Behaviour:
- Reset values: Arand_A=Arand_B=0, Asel_A=Asel_B=1, learning=0, valid=0, epsilon=EPS_INIT, episode=0, done=0, step counter=0, state=IDLE.
- LFSRs load SEED_A/SEED_B on reset.
- LFSRs: two independent 16-bit Galois LFSRs, shift right, tap mask 16'hB400.
  - Per step: next = (cur>>1) ^ (cur[0] ? 16'hB400 : 0).
  - They advance only on accepted steps, never on idle cycles.
  - They are never reloaded except on rst.
- Step latency: step accepted in cycle t. In cycle t+1:
  - Arand_x = next_x[1:0].
  - In RUN: Asel_x = (next_x >= epsilon), unsigned 16-bit compare; valid=1.
  - Outside RUN: Asel_x = 1.
  - Outputs hold until the next accepted step. valid is high for exactly one cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE: learning=0. On start, go to RUN; epsilon=EPS_INIT, episode=0, step counter=0.
  - RUN: learning=1.
    - Each accepted step increments the step counter.
    - When the step counter reaches STEPS_PER_EPISODE-1 and a step is accepted:
      - step counter resets to 0;
      - episode increments;
      - epsilon <= max(epsilon - (epsilon >> DECAY_SHIFT), EPS_MIN).
    - If the incremented episode equals N_EPISODES, go to DONE.
    - The step that ends an episode uses the pre-decay epsilon for its Asel.
  - DONE: learning=0, done=1, epsilon and episode frozen. On start, go to RUN with the same reinitialisation as from IDLE.
- Steps are accepted in every state, with valid pulsing each time.
- start and step in the same cycle: start is processed; the step is dropped (no LFSR advance, no valid).
- start while already in RUN: reinitialise epsilon, episode and step counter; stay in RUN.
- Decay arithmetic: 16-bit unsigned, no underflow possible. The floor clamp is applied after the subtraction.
- rst asserted mid-episode: every register returns to its reset value in the next cycle, and any in-flight valid is suppressed.

Optional Feature:
Macro EGREEDY_FIXED_EPS_EN.
- Defined: epsilon stays at EPS_INIT for the whole run. Episode counting, DONE entry and `done` are unchanged.
- Undefined: geometric decay as specified above.

Decomposition:
- Package egreedy_pkg holds:
  - FSM state enum {IDLE, RUN, DONE};
  - LFSR width 16 and tap mask 16'hB400;
  - epsilon width 16 and episode width 8.
- Sub-module lfsr16_galois (inputs: clk, rst, adv, seed; output: q), instantiated twice, for A and B.

Test Plan:
1. Reset, then one step in IDLE. Cycle+1: Arand_A=0 (LFSR A 0xACE1→0xE270), Asel_A=1, learning=0, valid=1.
2. start, then one step (defaults). Cycle+1: LFSR A=0xE270 < 0xFFFF, so Asel_A=0; learning=1; valid=1.
3. Set STEPS_PER_EPISODE=4, N_EPISODES=2. start, then 4 steps: epsilon 0xFFFF→0xFC00, episode=1. 4 more steps: epsilon 0xF810, episode=2, done=1, learning=0.
4. Set EPS_INIT=16'h0D00, DECAY_SHIFT=1, STEPS_PER_EPISODE=1. start, then 1 step: epsilon clamps to 16'h0CCD and holds on further episodes.
5. start and step in the same cycle: no valid, LFSR unchanged (next step still yields 0xE270). Then rst mid-episode: all outputs return to reset values in the following cycle.
6. With EGREEDY_FIXED_EPS_EN defined, run scenario 3: epsilon stays 0xFFFF; done=1 after 8 steps.
